// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory bus plus decode-side handshake of the fetch stage.
// master = fetch unit side, slave = memory/decode environment side.
interface fetch_unit_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32
);
    logic                   imem_req_o;
    logic [ADDR_WIDTH-1:0]  imem_addr_o;
    logic                   imem_gnt_i;
    logic                   imem_rvalid_i;
    logic [INSTR_WIDTH-1:0] imem_rdata_i;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic [ADDR_WIDTH-1:0]  pc_o;
    logic                   instr_valid_o;
    logic                   decode_ready_i;
    logic                   pcsrc_i;
    logic [ADDR_WIDTH-1:0]  imm_ext_i;
    logic                   flush_i;
    logic [ADDR_WIDTH-1:0]  flush_pc_i;
    logic                   misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misalign_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, decode_ready_i,
               pcsrc_i, imm_ext_i, flush_i, flush_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o, misalign_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, decode_ready_i,
               pcsrc_i, imm_ext_i, flush_i, flush_pc_i
    );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select (flush > pcsrc > +4) with alignment handling.
// FETCH_MISALIGN_CHECK_EN: report misaligned targets instead of clearing bits [1:0].
module pc_next #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_pc_i,
    input  logic                  pcsrc_i,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [ADDR_WIDTH-1:0] imm_ext_i,
    output logic [ADDR_WIDTH-1:0] target_o,
    output logic                  misaligned_o
);

    logic [ADDR_WIDTH-1:0] raw_target;

    always_comb begin
        raw_target = pc_i + ADDR_WIDTH'(4);
        if (flush_i) begin
            raw_target = flush_pc_i;
        end else if (pcsrc_i) begin
            raw_target = pc_i + imm_ext_i;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    assign target_o     = raw_target;
    assign misaligned_o = |raw_target[1:0];
`else
    assign target_o     = raw_target & ~ADDR_WIDTH'(3);
    assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, one outstanding imem request, valid/ready to decode.
// FETCH_MISALIGN_CHECK_EN adds the HALT state and a sticky misalign_o trap.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    fetch_unit_if.master bus
);

    fetch_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   drop_q, drop_d;
    logic                   misalign_q, misalign_d;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   target_mis;

    pc_next #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
        .flush_i      (bus.flush_i),
        .flush_pc_i   (bus.flush_pc_i),
        .pcsrc_i      (bus.pcsrc_i),
        .pc_i         (pc_q),
        .imm_ext_i    (bus.imm_ext_i),
        .target_o     (target),
        .misaligned_o (target_mis)
    );

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        drop_d     = drop_q;
        misalign_d = misalign_q;

        unique case (state_q)
            REQ: begin
                if (bus.flush_i) begin
                    // A grant in the flush cycle is for the old address; its data must be discarded.
                    if (bus.imem_gnt_i) drop_d = 1'b1;
                    if (target_mis) begin
                        state_d    = HALT;
                        pc_d       = target;
                        misalign_d = 1'b1;
                    end else begin
                        fetch_pc_d = target;
                        if (bus.imem_gnt_i) state_d = WAIT;
                    end
                end else if (bus.imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.flush_i) begin
                    drop_d = !bus.imem_rvalid_i;
                    if (target_mis) begin
                        state_d    = HALT;
                        pc_d       = target;
                        misalign_d = 1'b1;
                    end else begin
                        fetch_pc_d = target;
                        state_d    = bus.imem_rvalid_i ? REQ : WAIT;
                    end
                end else if (bus.imem_rvalid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = bus.imem_rdata_i;
                        pc_d    = fetch_pc_q;
                        state_d = VALID;
                    end
                end
            end
            VALID: begin
                if (bus.flush_i || bus.decode_ready_i) begin
                    if (target_mis) begin
                        state_d    = HALT;
                        pc_d       = target;
                        misalign_d = 1'b1;
                    end else begin
                        fetch_pc_d = target;
                        state_d    = REQ;
                    end
                end
            end
            HALT: begin
                // A request may still be in flight when HALT is entered; absorb its response here.
                if (bus.imem_rvalid_i) drop_d = 1'b0;
                if (bus.flush_i) begin
                    if (target_mis) begin
                        pc_d = target;
                    end else begin
                        fetch_pc_d = target;
                        misalign_d = 1'b0;
                        state_d    = REQ;
                    end
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= INSTR_WIDTH'(NOP_INSTR);
            drop_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    // Request is held off while reset is asserted so it first rises right after release.
    assign bus.imem_req_o    = rst_ni && (state_q == REQ);
    assign bus.imem_addr_o   = fetch_pc_q;
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc_q;
    assign bus.instr_valid_o = (state_q == VALID);
    assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected request addresses and delivered instructions queued at stimulus time.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic [31:0] gnt_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return 32'h0050_0093 + {a[23:0], 8'h00};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc, input bit src, input logic [31:0] imm);
        logic [31:0] s;
        s = src ? pc + imm : pc + 32'd4;
        return s & 32'hFFFF_FFFC;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_addr_pop(input string tag);
        if (exp_addr_q.size() == 0) chk({tag, "_q_empty"}, 32'd1, 32'd0);
        else chk(tag, bus.imem_addr_o, exp_addr_q.pop_front());
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (bus.imem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
        ok = (bus.imem_req_o === 1'b1);
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input int gnt_dly);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        gnt_addr = bus.imem_addr_o;
        chk_addr_pop("req_addr");
        for (int i = 0; i < gnt_dly; i++) begin
            bus.imem_gnt_i = 1'b0;
            tick();
            chk("addr_hold", bus.imem_addr_o, gnt_addr);
            chk("req_hold", bus.imem_req_o, 1'b1);
        end
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.imem_gnt_i = 1'b0;
        chk("req_low_wait", bus.imem_req_o, 1'b0);
    endtask

    task automatic do_rsp(input int dly, input bit dropped);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("valid_low_wait", bus.instr_valid_o, 1'b0);
        end
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_data(gnt_addr);
        tick();
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'hDEAD_BEEF;
        if (!dropped) begin
            exp_pc_q.push_back(gnt_addr);
            exp_ins_q.push_back(mem_data(gnt_addr));
        end
    endtask

    task automatic wait_valid_pop(output logic [31:0] epc, output bit ok);
        int n = 0;
        epc = 32'h0;
        while (bus.instr_valid_o !== 1'b1 && n < 20) begin tick(); n++; end
        ok = (bus.instr_valid_o === 1'b1);
        if (!ok) begin chk("valid_timeout", 32'd0, 32'd1); return; end
        if (exp_pc_q.size() == 0) begin chk("instr_q_empty", 32'd1, 32'd0); ok = 1'b0; return; end
        epc = exp_pc_q.pop_front();
        chk("pc_o", bus.pc_o, epc);
        chk("instr_o", bus.instr_o, exp_ins_q.pop_front());
    endtask

    task automatic consume(input int stall, input bit src, input logic [31:0] imm);
        logic [31:0] epc;
        logic [31:0] ins0;
        bit ok;
        wait_valid_pop(epc, ok);
        if (!ok) return;
        ins0 = bus.instr_o;
        for (int i = 0; i < stall; i++) begin
            bus.decode_ready_i = 1'b0;
            tick();
            chk("stall_valid", bus.instr_valid_o, 1'b1);
            chk("stall_pc", bus.pc_o, epc);
            chk("stall_instr", bus.instr_o, ins0);
            chk("stall_no_req", bus.imem_req_o, 1'b0);
        end
        bus.decode_ready_i = 1'b1;
        bus.pcsrc_i        = src;
        bus.imm_ext_i      = imm;
        exp_addr_q.push_back(next_pc(epc, src, imm));
        tick();
        bus.decode_ready_i = 1'b0;
        bus.pcsrc_i        = 1'b0;
        bus.imm_ext_i      = 32'h0;
        chk("valid_drop", bus.instr_valid_o, 1'b0);
    endtask

    task automatic flush_req(input logic [31:0] tgt);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        chk_addr_pop("pre_flush_addr");
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = tgt;
        tick();
        bus.flush_i = 1'b0;
        chk("flush_req_addr", bus.imem_addr_o, tgt);
        exp_addr_q.push_back(tgt);
    endtask

    task automatic chk_reset_outputs;
        chk("rst_req", bus.imem_req_o, 1'b0);
        chk("rst_valid", bus.instr_valid_o, 1'b0);
        chk("rst_instr", bus.instr_o, 32'h0000_0013);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_misalign", bus.misalign_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] epc;
        bit ok;
        rst_ni             = 1'b0;
        bus.imem_gnt_i     = 1'b0;
        bus.imem_rvalid_i  = 1'b0;
        bus.imem_rdata_i   = 32'h0;
        bus.decode_ready_i = 1'b0;
        bus.pcsrc_i        = 1'b0;
        bus.imm_ext_i      = 32'h0;
        bus.flush_i        = 1'b0;
        bus.flush_pc_i     = 32'h0;
        repeat (3) tick();
        chk_reset_outputs();

        // Sequential fetch with immediate grant/rvalid
        rst_ni = 1'b1;
        exp_addr_q.push_back(32'h0);
        do_req(0);
        do_rsp(0, 1'b0);
        chk("valid_cycle3", bus.instr_valid_o, 1'b1);
        consume(0, 1'b0, 32'h0);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);
        do_req(0); do_rsp(0, 1'b0); consume(5, 1'b1, 32'h8);
        do_req(0); do_rsp(1, 1'b0); consume(0, 1'b1, 32'hFFFF_FFF8);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b1, 32'h8);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);

        // Flush while waiting, response two cycles later is dropped
        do_req(0);
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h100;
        tick();
        bus.flush_i = 1'b0;
        exp_addr_q.push_back(32'h100);
        do_rsp(2, 1'b1);
        chk("drop_no_valid", bus.instr_valid_o, 1'b0);
        chk("drop_back_req", bus.imem_req_o, 1'b1);
        do_req(4); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);

        // Flush in REQ coinciding with a grant for the old address
        wait_req(ok);
        chk_addr_pop("flushgnt_old_addr");
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h200;
        bus.imem_gnt_i = 1'b1;
        tick();
        bus.flush_i    = 1'b0;
        bus.imem_gnt_i = 1'b0;
        gnt_addr       = 32'h104;
        do_rsp(0, 1'b1);
        chk("flushgnt_no_valid", bus.instr_valid_o, 1'b0);
        exp_addr_q.push_back(32'h200);
        do_req(0); do_rsp(0, 1'b0);

        // Flush in VALID kills the instruction despite a coincident handshake
        wait_valid_pop(epc, ok);
        bus.decode_ready_i = 1'b1;
        bus.flush_i        = 1'b1;
        bus.flush_pc_i     = 32'h300;
        tick();
        bus.decode_ready_i = 1'b0;
        bus.flush_i        = 1'b0;
        chk("flushvalid_drop", bus.instr_valid_o, 1'b0);
        exp_addr_q.push_back(32'h300);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);

        // Address wrap at the top of the space
        flush_req(32'hFFFF_FFFC);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);
        do_req(0); do_rsp(0, 1'b0);

`ifdef FETCH_MISALIGN_CHECK_EN
        consume(0, 1'b0, 32'h0);
        flush_req(32'h20);
        do_req(0); do_rsp(0, 1'b0);
        wait_valid_pop(epc, ok);
        bus.decode_ready_i = 1'b1;
        bus.pcsrc_i        = 1'b1;
        bus.imm_ext_i      = 32'h6;
        tick();
        bus.decode_ready_i = 1'b0;
        bus.pcsrc_i        = 1'b0;
        bus.imm_ext_i      = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("halt_misalign", bus.misalign_o, 1'b1);
            chk("halt_no_req", bus.imem_req_o, 1'b0);
            chk("halt_no_valid", bus.instr_valid_o, 1'b0);
            chk("halt_pc", bus.pc_o, 32'h26);
            tick();
        end
        bus.flush_i    = 1'b1;
        bus.flush_pc_i = 32'h40;
        tick();
        bus.flush_i = 1'b0;
        chk("unhalt_misalign", bus.misalign_o, 1'b0);
        exp_addr_q.push_back(32'h40);
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);
`else
        // Misaligned branch target silently loses bits [1:0]
        consume(0, 1'b1, 32'h6);
        do_req(0);
        chk("no_misalign", bus.misalign_o, 1'b0);
        do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);
`endif

        // Reset in the middle of WAIT
        do_req(0);
        rst_ni = 1'b0;
        tick();
        chk_reset_outputs();
        exp_addr_q.delete();
        exp_pc_q.delete();
        exp_ins_q.delete();
        exp_addr_q.push_back(32'h0);
        rst_ni = 1'b1;
        do_req(0); do_rsp(0, 1'b0); consume(0, 1'b0, 32'h0);
        chk("sb_instr_empty", exp_pc_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
